// File: rtl/line_fetch_sched_if.sv
// Memory read port plus AXI-stream pixel output of the line fetch sequencer.
interface line_fetch_sched_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 20
);
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_rsp_valid;
    logic [WIDTH-1:0]  mem_rsp_data;
    logic              out_axis_tvalid;
    logic              out_axis_tready;
    logic              out_axis_tuser;
    logic              out_axis_tlast;
    logic [WIDTH-1:0]  out_axis_tdata;

    modport master (
        output mem_req_valid, mem_req_addr,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output out_axis_tvalid, out_axis_tuser, out_axis_tlast, out_axis_tdata,
        input  out_axis_tready
    );

    modport slave (
        input  mem_req_valid, mem_req_addr,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  out_axis_tvalid, out_axis_tuser, out_axis_tlast, out_axis_tdata,
        output out_axis_tready
    );
endinterface

// File: rtl/line_fetch_sched.sv
// Frame/line pixel fetch sequencer: word-addressed memory reads -> AXI-stream with tuser/tlast.
// Define LINE_FETCH_SCHED_DOUBLE_EN for vertical line doubling (each source line emitted twice).
module line_fetch_sched #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned ADDR_W   = 20,
    parameter int unsigned H_PIXELS = 640,
    parameter int unsigned V_LINES  = 480
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               frame_start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [ADDR_W-1:0]  stride,
    line_fetch_sched_if.master bus,
    output logic               busy,
    output logic               frame_done,
    output logic               overrun
);
    localparam int unsigned CW = 10;
    localparam logic [CW-1:0] LAST_X = CW'(H_PIXELS - 1);
    localparam logic [CW-1:0] LAST_Y = CW'(V_LINES - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, PUSH} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     x_q, x_d, y_q, y_d;
    logic [ADDR_W-1:0] line_ptr_q, line_ptr_d;
    logic [ADDR_W-1:0] word_ptr_q, word_ptr_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic [ADDR_W-1:0] next_line;
    logic [WIDTH-1:0]  tdata_q, tdata_d;
    logic              tuser_q, tuser_d, tlast_q, tlast_d;
    logic              req_valid_q, req_valid_d, tvalid_q, tvalid_d;
    logic              busy_q, busy_d, done_q, done_d, overrun_q, overrun_d;
    logic              adv_line;

`ifdef LINE_FETCH_SCHED_DOUBLE_EN
    // Source line advances only after the second (odd) copy of each line.
    assign adv_line = y_q[0];
`else
    assign adv_line = 1'b1;
`endif

    assign next_line = line_ptr_q + stride_q;

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        line_ptr_d = line_ptr_q;
        word_ptr_d = word_ptr_q;
        stride_d   = stride_q;
        tdata_d    = tdata_q;
        tuser_d    = tuser_q;
        tlast_d    = tlast_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        overrun_d  = overrun_q | (frame_start & busy_q);

        unique case (state_q)
            IDLE: begin
                if (frame_start && enable) begin
                    line_ptr_d = base_addr;
                    word_ptr_d = base_addr;
                    stride_d   = stride;
                    x_d        = '0;
                    y_d        = '0;
                    busy_d     = 1'b1;
                    state_d    = REQ;
                end
            end
            REQ: begin
                if (bus.mem_req_ready) state_d = WAIT;
            end
            WAIT: begin
                if (bus.mem_rsp_valid) begin
                    tdata_d = bus.mem_rsp_data;
                    tuser_d = (x_q == '0) && (y_q == '0);
                    tlast_d = (x_q == LAST_X);
                    state_d = PUSH;
                end
            end
            PUSH: begin
                if (bus.out_axis_tready) begin
                    if (!tlast_q) begin
                        x_d        = x_q + CW'(1);
                        word_ptr_d = word_ptr_q + ADDR_W'(1);
                        state_d    = REQ;
                    end else if (y_q != LAST_Y) begin
                        x_d     = '0;
                        y_d     = y_q + CW'(1);
                        state_d = REQ;
                        if (adv_line) begin
                            line_ptr_d = next_line;
                            word_ptr_d = next_line;
                        end else begin
                            word_ptr_d = line_ptr_q;
                        end
                    end else begin
                        x_d     = '0;
                        y_d     = '0;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        req_valid_d = (state_d == REQ);
        tvalid_d    = (state_d == PUSH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            line_ptr_q  <= '0;
            word_ptr_q  <= '0;
            stride_q    <= '0;
            tdata_q     <= '0;
            tuser_q     <= 1'b0;
            tlast_q     <= 1'b0;
            req_valid_q <= 1'b0;
            tvalid_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            line_ptr_q  <= line_ptr_d;
            word_ptr_q  <= word_ptr_d;
            stride_q    <= stride_d;
            tdata_q     <= tdata_d;
            tuser_q     <= tuser_d;
            tlast_q     <= tlast_d;
            req_valid_q <= req_valid_d;
            tvalid_q    <= tvalid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.mem_req_valid   = req_valid_q;
    assign bus.mem_req_addr    = word_ptr_q;
    assign bus.out_axis_tvalid = tvalid_q;
    assign bus.out_axis_tuser  = tuser_q;
    assign bus.out_axis_tlast  = tlast_q;
    assign bus.out_axis_tdata  = tdata_q;
    assign busy                = busy_q;
    assign frame_done          = done_q;
    assign overrun             = overrun_q;
endmodule

// File: doc/line_fetch_sched.md
Name: line_fetch_sched

Overview:
- Frame/line sequencer that reads pixels from a word-addressed memory read port and emits them as an AXI-stream.
- Output is tuser on the first pixel of each frame and tlast on the last pixel of each line.
- Feeds the ping-pong line buffer stream toward the video output.
- Arms on a frame-start pulse from video timing, walks H_PIXELS x V_LINES words from a programmable base/stride, and honours downstream backpressure.

Parameters:
- WIDTH, 32, pixel/data word width
- ADDR_W, 20, memory word-address width
- H_PIXELS, 640, pixels per line (max 1023)
- V_LINES, 480, lines per frame (max 1023)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- enable  in  1  allow new frames to start
- frame_start  in  1  one-cycle pulse from video timing
- base_addr  in  ADDR_W  frame base word address, sampled at frame start
- stride  in  ADDR_W  words between line starts, sampled at frame start
- mem_req_valid  out  1  read request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDR_W  read word address
- mem_rsp_valid  in  1  read data valid (no backpressure)
- mem_rsp_data  in  WIDTH  read data
- out_axis_tvalid  out  1  pixel valid
- out_axis_tready  in  1  downstream ready
- out_axis_tuser  out  1  first pixel of frame
- out_axis_tlast  out  1  last pixel of line
- out_axis_tdata  out  WIDTH  pixel
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse after last pixel accepted
- overrun  out  1  sticky: frame_start arrived while busy; cleared only by rst

Behaviour:
- Reset values: all outputs 0. State IDLE; counters x=0, y=0.
- States: IDLE, REQ, WAIT, PUSH.
- IDLE:
  - On frame_start && enable, latch base_addr into line_ptr and word_ptr, and latch stride.
  - Set x=0, y=0, busy=1, go REQ next cycle.
  - frame_start with enable=0 is ignored.
- REQ:
  - mem_req_valid=1, mem_req_addr=word_ptr.
  - On mem_req_ready go WAIT.
  - Valid and address are held stable until accepted.
- WAIT:
  - On mem_rsp_valid, capture data into the output register.
  - Set tuser = (x==0 && y==0) and tlast = (x==H_PIXELS-1), go PUSH.
  - At most one read is outstanding.
- PUSH:
  - out_axis_tvalid=1. Data, tuser and tlast are stable until tready.
  - On tready with x<H_PIXELS-1: x++, word_ptr++, go REQ.
  - On tready with tlast and y<V_LINES-1: x=0, y++, line_ptr+=stride, word_ptr=line_ptr+stride, go REQ.
  - On tready with tlast and y==V_LINES-1: frame_done=1 for one cycle, busy=0, go IDLE.
- Address arithmetic is unsigned modulo 2^ADDR_W; wrap is silent.
- frame_start while busy: ignored for sequencing, sets overrun. The current frame continues unaffected.
- frame_start in the same cycle as the frame_done transition is also ignored (busy still 1) and sets overrun.
- enable deassert mid-frame: the current frame completes; no new frame starts.
- mem_rsp_valid outside WAIT: ignored.
- rst mid-frame: immediate return to IDLE, all outputs 0. Any in-flight response is discarded. overrun cleared.
- Minimum cost: 3 cycles per pixel (REQ, WAIT, PUSH) with zero-latency memory and tready held 1.

Optional Feature:
- LINE_FETCH_SCHED_DOUBLE_EN: vertical line doubling. Each source line is fetched and emitted twice.
  - line_ptr advances by stride only after odd output lines (y[0]==1).
  - Output is still V_LINES lines with tlast on each; tuser only on the first pixel of output line 0.
- Without the macro: every output line advances line_ptr by stride.

Test Plan:
- H_PIXELS=4, V_LINES=3, base=0x100, stride=0x10, frame_start pulse, tready=1, memory returns data=addr next cycle:
  - addresses 0x100-0x103, 0x110-0x113, 0x120-0x123;
  - tuser only on data 0x100; tlast on 0x103/0x113/0x123;
  - frame_done one pulse; busy 1 to 0.
- Same frame, tready toggled 1/0 every cycle: identical data/tuser/tlast sequence. Output fields hold stable while tvalid && !tready. No extra mem requests.
- mem_req_ready held 0 for 5 cycles in REQ: mem_req_valid and addr stay constant, then exactly one request is accepted.
- frame_start pulsed at line 1 of a frame: overrun=1 and remains set. Frame finishes with 12 pixels. Next frame_start in IDLE starts a new frame.
- rst asserted mid-line 1: next cycle all outputs 0, busy=0. A following frame_start restarts at base with tuser on the first pixel.
- With LINE_FETCH_SCHED_DOUBLE_EN, H=4, V=4, base=0x100, stride=0x10: line addresses 0x100, 0x100, 0x110, 0x110; tuser only once.
